// File: rtl/rca_add_scheduler.sv
// rca_add_scheduler
//   Shares one 16-bit ripple-carry adder among NUM_REQ requesters with
//   round-robin arbitration. Each granted request is a 32-bit add executed as
//   two passes through the shared adder: the low half first, then the high
//   half fed by the registered low-half carry.
//
// Configuration macro: RCA_SCHED_OVF_EN
//   When defined, adds the registered signed-overflow output ovf.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-requester request, held high until that requester's done
//   a_bus      operand A, requester i at [32*i+31:32*i]
//   b_bus      operand B, same packing as a_bus
//   cin        per-requester carry-in
//   grant      one-hot served requester, high from LO through DONE
//   busy       high whenever the FSM is not idle
//   done       one-cycle result-valid strobe
//   done_id    index of the requester whose result is on sum/cout
//   sum        registered 32-bit sum
//   cout       carry out of bit 31
//   ovf        (RCA_SCHED_OVF_EN only) signed 32-bit overflow
//   state_dbg  current FSM state (0 idle, 1 lo, 2 hi, 3 done)
//
// Handshake: a requester raises req and holds it until it sees done with its
// own done_id; it drops req at the edge that ends the done cycle. The FSM only
// samples req in IDLE, which is reached one edge after DONE, so a request is
// never served twice.

module rca_16bit_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic carry;

    // Bit-serial ripple: carry is rewritten stage by stage inside one block.
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

module rca_add_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] a_bus,
    input  logic [NUM_REQ*32-1:0] b_bus,
    input  logic [NUM_REQ-1:0]    cin,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    output logic                  done,
    output logic [ID_W-1:0]       done_id,
    output logic [31:0]           sum,
    output logic                  cout,
`ifdef RCA_SCHED_OVF_EN
    output logic                  ovf,
`endif
    output logic [1:0]            state_dbg
);
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   served;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic              op_cin;
    logic [15:0]       lo_sum;
    logic              c16;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_vld;
    logic [ID_W-1:0]   cand_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic              sel_cin;
    logic [ID_W-1:0]   next_ptr;

    logic [15:0]       add_a;
    logic [15:0]       add_b;
    logic              add_cin;
    logic [15:0]       add_sum;
    logic              add_cout;

    // Round-robin pick: scan offsets from the far end down to 0 so the set
    // bit closest at-or-after rr_ptr is the last one written and wins.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand_idx]) begin
                pick_idx = cand_idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Operand and grant selection for the picked requester.
    always_comb begin
        sel_a       = '0;
        sel_b       = '0;
        sel_cin     = 1'b0;
        pick_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                sel_a          = a_bus[32*i +: 32];
                sel_b          = b_bus[32*i +: 32];
                sel_cin        = cin[i];
                pick_onehot[i] = 1'b1;
            end
        end
    end

    assign next_ptr = (int'(served) == NUM_REQ - 1) ? '0 : served + ID_W'(1);

    // The shared adder sees the low half in LO and the high half otherwise;
    // its output is only captured in LO and HI.
    always_comb begin
        if (state == S_LO) begin
            add_a   = op_a[15:0];
            add_b   = op_b[15:0];
            add_cin = op_cin;
        end else begin
            add_a   = op_a[31:16];
            add_b   = op_b[31:16];
            add_cin = c16;
        end
    end

    rca_16bit_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            served  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_cin  <= 1'b0;
            lo_sum  <= '0;
            c16     <= 1'b0;
            grant   <= '0;
            done    <= 1'b0;
            done_id <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef RCA_SCHED_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        op_cin <= sel_cin;
                        served <= pick_idx;
                        grant  <= pick_onehot;
                        state  <= S_LO;
                    end
                end
                S_LO: begin
                    lo_sum <= add_sum;
                    c16    <= add_cout;
                    state  <= S_HI;
                end
                S_HI: begin
                    sum     <= {add_sum, lo_sum};
                    cout    <= add_cout;
`ifdef RCA_SCHED_OVF_EN
                    // Carry into bit 31 recovered from the sum bit and operands.
                    ovf     <= (add_sum[15] ^ op_a[31] ^ op_b[31]) ^ add_cout;
`endif
                    done    <= 1'b1;
                    done_id <= served;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    done   <= 1'b0;
                    grant  <= '0;
                    rr_ptr <= next_ptr;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_rca_add_scheduler.sv
// Directed bench for rca_add_scheduler: a vector table of single requests
// with hand-computed results, plus sequences for round-robin order, wrap,
// reset during an operation and operand/req changes while in flight.
module tb_rca_add_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] a_bus;
    logic [127:0] b_bus;
    logic [3:0]   cin;
    logic [3:0]   grant;
    logic         busy;
    logic         done;
    logic [1:0]   done_id;
    logic [31:0]  sum;
    logic         cout;
    logic [1:0]   state_dbg;
`ifdef RCA_SCHED_OVF_EN
    logic         ovf;
`endif

    logic [31:0] a_arr [4];
    logic [31:0] b_arr [4];
    logic        cin_arr [4];

    assign a_bus = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign b_bus = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};
    assign cin   = {cin_arr[3], cin_arr[2], cin_arr[1], cin_arr[0]};

    rca_add_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .cin       (cin),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .sum       (sum),
        .cout      (cout),
`ifdef RCA_SCHED_OVF_EN
        .ovf       (ovf),
`endif
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [8];

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One isolated request from IDLE; fixed latency checked edge by edge.
    task automatic run_single(input vec_t v);
        logic [3:0] exp_grant;
        exp_grant      = 4'b0001 << v.idx;
        a_arr[v.idx]   = v.a;
        b_arr[v.idx]   = v.b;
        cin_arr[v.idx] = v.c;
        req            = exp_grant;
        tick();
        check("grant_lo", 32'(grant), 32'(exp_grant));
        check("busy_lo", 32'(busy), 32'd1);
        check("done_lo", 32'(done), 32'd0);
        tick();
        check("grant_hi", 32'(grant), 32'(exp_grant));
        check("done_hi", 32'(done), 32'd0);
        tick();
        check("done_set", 32'(done), 32'd1);
        check("done_id", 32'(done_id), 32'(v.idx));
        check("sum", sum, v.exp_sum);
        check("cout", 32'(cout), 32'(v.exp_cout));
        check("grant_done", 32'(grant), 32'(exp_grant));
`ifdef RCA_SCHED_OVF_EN
        check("ovf", 32'(ovf), 32'(v.exp_ovf));
`endif
        req = '0;
        tick();
        check("done_clear", 32'(done), 32'd0);
        check("grant_clear", 32'(grant), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        check("sum_hold", sum, v.exp_sum);
    endtask

    // Bounded wait for done; returns the number of edges taken.
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!done && cycles < 12);
        check("done_seen", 32'(done), 32'd1);
    endtask

    function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {32'd0, c};
    endfunction

    initial begin
        int          cyc;
        logic [32:0] m;
        logic        saw_done;

        for (int i = 0; i < 4; i++) begin
            a_arr[i]   = '0;
            b_arr[i]   = '0;
            cin_arr[i] = 1'b0;
        end

        vecs[0] = '{0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs[1] = '{2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{1, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[3] = '{3, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{0, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[6] = '{3, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{2, 32'hDEADBEEF, 32'h01010101, 1'b0, 32'hDFAEBFF0, 1'b0, 1'b0};

        // Asynchronous reset state, checked before any clock edge matters.
        #2 rst = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
`ifdef RCA_SCHED_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("idle_no_req", 32'(busy), 32'd0);

        // Table of isolated requests.
        for (int i = 0; i < 8; i++) run_single(vecs[i]);

        // All four requesting from a fresh pointer: order 0,1,2,3.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_arr[i]   = 32'h0000FFFF + 32'(i) * 32'h10010003;
            b_arr[i]   = 32'hFFFF8001 - 32'(i) * 32'h00300007;
            cin_arr[i] = 1'(i);
            m = model_add(a_arr[i], b_arr[i], cin_arr[i]);
            exp_q.push_back(m[31:0]);
        end
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_done(cyc);
            check("rr_latency", 32'(cyc), 32'd3);
            check("rr_order", 32'(done_id), 32'(i));
            check("rr_sum", sum, exp_q.pop_front());
            if (i == 3) req = '0;
            tick();
            check("rr_pulse", 32'(done), 32'd0);
        end

        // Serve 1, then 1 and 3 together: 3 goes first, then wrap to 1.
        run_single('{1, 32'h00000005, 32'h00000007, 1'b0, 32'h0000000C, 1'b0, 1'b0});
        a_arr[3] = 32'h00010000; b_arr[3] = 32'h0000FFFF; cin_arr[3] = 1'b1;
        a_arr[1] = 32'h40000000; b_arr[1] = 32'h40000000; cin_arr[1] = 1'b0;
        req = 4'b1010;
        wait_done(cyc);
        check("wrap_first", 32'(done_id), 32'd3);
        check("wrap_sum3", sum, 32'h00020000);
        tick();
        wait_done(cyc);
        check("wrap_second", 32'(done_id), 32'd1);
        check("wrap_sum1", sum, 32'h80000000);
        req = '0;
        tick();

        // Reset while request 0 is in HI: nothing completes, pointer clears.
        a_arr[0] = 32'h12345678; b_arr[0] = 32'h87654321; cin_arr[0] = 1'b0;
        req = 4'b0001;
        tick();
        tick();
        check("pre_rst_in_hi", 32'(state_dbg), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_sum", sum, 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_done_id", 32'(done_id), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = '0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_rst", 32'(saw_done), 32'd0);
        check("sum_after_rst", sum, 32'd0);

        // Pointer must be back at 0: requesters 0 and 3 pick 0.
        req = 4'b1001;
        wait_done(cyc);
        check("ptr_reset_pick", 32'(done_id), 32'd0);
        check("ptr_reset_sum", sum, 32'h99999999);
        req = '0;
        tick();

        // Requester 2 changes operands and drops req right after grant.
        a_arr[2] = 32'h0001FFFF; b_arr[2] = 32'h0000FFFF; cin_arr[2] = 1'b1;
        req = 4'b0100;
        tick();
        check("inflight_grant", 32'(grant), 32'b0100);
        a_arr[2] = 32'hFFFFFFFF; b_arr[2] = 32'hFFFFFFFF; cin_arr[2] = 1'b0;
        req = '0;
        wait_done(cyc);
        check("inflight_latency", 32'(cyc), 32'd2);
        check("inflight_id", 32'(done_id), 32'd2);
        check("inflight_sum", sum, 32'h0002FFFF);
        check("inflight_cout", 32'(cout), 32'd0);
        tick();
        tick();
        check("inflight_no_reserve", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
